// File: rtl/shifter_seq.sv
// Operand-2 sequencer: fetches Rs when needed, samples shifter_mux for the amount,
// then performs an iterative barrel shift and hands result/carry to execute.
module shifter_seq #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        imm_op,
  input  logic        reg_shift,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  imm8,
  input  logic [3:0]  rotate_imm,
  input  logic [4:0]  shift_imm,
  input  logic [3:0]  rs_addr,
  input  logic [31:0] rm_data,
  input  logic        c_in,
  output logic        rf_req,
  output logic [3:0]  rf_addr,
  input  logic        rf_gnt,
  input  logic [31:0] rf_data,
  output logic [1:0]  smux_sel,
  output logic [3:0]  smux_rotate_imm,
  output logic [4:0]  smux_shift_imm,
  output logic [31:0] smux_rs,
  input  logic [31:0] smux_shifter,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] result,
  output logic        carry_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_RS_FETCH, S_AMOUNT, S_SHIFT, S_DONE
  } state_t;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_RRX = 3'd4;

  state_t state, state_nxt;

  logic [1:0]  sel_q;
  logic [1:0]  type_q;
  logic [7:0]  imm8_q;
  logic [3:0]  rot_q;
  logic [4:0]  shimm_q;
  logic [3:0]  rs_addr_q;
  logic [31:0] rm_q;
  logic        cin_q;
  logic [31:0] rs_q;

  logic [31:0] d_q;
  logic        c_q;
  logic [2:0]  op_q;
  logic [5:0]  rem_q;

  logic [7:0]  amt8;
  logic [4:0]  amt5;
  logic [31:0] amt_d;
  logic        amt_c;
  logic [2:0]  amt_op;
  logic [5:0]  amt_n;

  logic [31:0] sh_d;
  logic        sh_c;
  logic [5:0]  sh_rem;
  logic [32:0] sh_step;

  logic        unused_bits;
  assign unused_bits = ^smux_shifter[31:8];

  // One bit position of shift; returns {carry_out, data}. RRX fills with the incoming carry.
  function automatic logic [32:0] shift_step(input logic [2:0] op, input logic [31:0] d,
                                             input logic c);
    logic [32:0] r;
    case (op)
      OP_LSL:  r = {d[31], d[30:0], 1'b0};
      OP_LSR:  r = {d[0], 1'b0, d[31:1]};
      OP_ASR:  r = {d[0], d[31], d[31:1]};
      OP_ROR:  r = {d[0], d[0], d[31:1]};
      default: r = {d[0], c, d[31:1]};
    endcase
    return r;
  endfunction

  assign amt8 = smux_shifter[7:0];
  assign amt5 = amt8[4:0];

  // Amount decode: turns the mux output into a step count, start data and mode
  always_comb begin
    amt_d  = rm_q;
    amt_c  = cin_q;
    amt_op = {1'b0, type_q};
    amt_n  = 6'd0;
    case (sel_q)
      2'd0: begin
        amt_d  = {24'd0, imm8_q};
        amt_op = OP_ROR;
        amt_n  = {1'b0, amt8[3:0], 1'b0};
      end
      2'd1: begin
        case (type_q)
          2'b00:        amt_n = {1'b0, amt5};
          2'b01, 2'b10: amt_n = (amt5 == 5'd0) ? 6'd32 : {1'b0, amt5};
          default: begin
            if (amt5 == 5'd0) begin
              amt_op = OP_RRX;
              amt_n  = 6'd1;
            end else begin
              amt_n  = {1'b0, amt5};
            end
          end
        endcase
      end
      default: begin
        case (type_q)
          2'b00, 2'b01: amt_n = (amt8 > 8'd33) ? 6'd33 : amt8[5:0];
          2'b10:        amt_n = (amt8 > 8'd32) ? 6'd32 : amt8[5:0];
          default: begin
            amt_n = {1'b0, amt5};
            // rotate by a nonzero multiple of 32: data unchanged, carry is bit 31
            if (amt8 != 8'd0 && amt5 == 5'd0) amt_c = rm_q[31];
          end
        endcase
      end
    endcase
  end

  always_comb begin
    sh_d    = d_q;
    sh_c    = c_q;
    sh_rem  = rem_q;
    sh_step = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (sh_rem != 6'd0) begin
        sh_step = shift_step(op_q, sh_d, sh_c);
        sh_c    = sh_step[32];
        sh_d    = sh_step[31:0];
        sh_rem  = sh_rem - 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (op_valid) state_nxt = (!imm_op && reg_shift) ? S_RS_FETCH : S_AMOUNT;
      S_RS_FETCH: if (rf_gnt) state_nxt = S_AMOUNT;
      S_AMOUNT:   state_nxt = (amt_n != 6'd0) ? S_SHIFT : S_DONE;
      S_SHIFT:    if (sh_rem == 6'd0) state_nxt = S_DONE;
      S_DONE:     if (res_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state == S_IDLE);
    rf_req    = (state == S_RS_FETCH);
    res_valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= '0;
      type_q    <= '0;
      imm8_q    <= '0;
      rot_q     <= '0;
      shimm_q   <= '0;
      rs_addr_q <= '0;
      rm_q      <= '0;
      cin_q     <= 1'b0;
      rs_q      <= '0;
      d_q       <= '0;
      c_q       <= 1'b0;
      op_q      <= '0;
      rem_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            sel_q     <= imm_op ? 2'd0 : (reg_shift ? 2'd2 : 2'd1);
            type_q    <= shift_type;
            imm8_q    <= imm8;
            rot_q     <= rotate_imm;
            shimm_q   <= shift_imm;
            rs_addr_q <= rs_addr;
            rm_q      <= rm_data;
            cin_q     <= c_in;
          end
        end
        S_RS_FETCH: if (rf_gnt) rs_q <= rf_data;
        S_AMOUNT: begin
          d_q   <= amt_d;
          c_q   <= amt_c;
          op_q  <= amt_op;
          rem_q <= amt_n;
        end
        S_SHIFT: begin
          d_q   <= sh_d;
          c_q   <= sh_c;
          rem_q <= sh_rem;
        end
        default: ;
      endcase
    end
  end

  assign rf_addr         = rs_addr_q;
  assign smux_sel        = sel_q;
  assign smux_rotate_imm = rot_q;
  assign smux_shift_imm  = shimm_q;
  assign smux_rs         = rs_q;
  assign result          = d_q;
  assign carry_out       = c_q;

endmodule
